// File: rtl/facto_seq.sv
// facto_seq: bus-master job sequencer for the factorial core.
// Takes one operand per job, programs the core over its slave port, waits for
// the completion interrupt (or a timeout), reads back the 128-bit result and
// hands it downstream with a valid/ready handshake. One job in flight at a time.
module facto_seq #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_operand,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_result,
    output logic         out_err,
    output logic         busy,
    output logic         s_sel,
    output logic         s_wr,
    output logic [15:0]  s_addr,
    output logic [63:0]  s_din,
    input  logic [63:0]  s_dout,
    input  logic         interrupt
);

    localparam logic [15:0] OFS_OPSTART  = 16'h0000;
    localparam logic [15:0] OFS_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFS_INTREN   = 16'h0018;
    localparam logic [15:0] OFS_OPERAND  = 16'h0020;
    localparam logic [15:0] OFS_RESULT_H = 16'h0028;
    localparam logic [15:0] OFS_RESULT_L = 16'h0030;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR1, S_CLR0, S_OPND, S_INTR, S_START,
        S_WAIT, S_RD_H, S_RD_L, S_FIN, S_ABORT, S_OUT
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [63:0]    r_operand;
    logic [31:0]    r_cnt;
    logic [31:0]    w_cnt_inc;
    logic           w_timeout;
    logic [127:0]   r_result;
    logic           r_err;
    logic           r_out_valid;

    logic           r_s_sel;
    logic           r_s_wr;
    logic [15:0]    r_s_addr;
    logic [63:0]    r_s_din;

    logic           w_sel;
    logic           w_wr;
    logic [15:0]    w_addr;
    logic [63:0]    w_din;

    assign w_cnt_inc = r_cnt + 32'd1;
    assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_inc == TIMEOUT_CYC[31:0]);

    assign in_ready   = (r_state == S_IDLE) && !reset;
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_err    = r_err;
    assign s_sel      = r_s_sel;
    assign s_wr       = r_s_wr;
    assign s_addr     = r_s_addr;
    assign s_din      = r_s_din;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state selection, then the bus access belonging to the state being
    // entered, so the registered bus lines carry each state's access during it.
    always_comb begin
        w_next = r_state;
        w_sel  = 1'b0;
        w_wr   = 1'b0;
        w_addr = '0;
        w_din  = '0;

        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_CLR1;
            S_CLR1:  w_next = S_CLR0;
            S_CLR0:  w_next = S_OPND;
            S_OPND:  w_next = S_INTR;
            S_INTR:  w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (interrupt)      w_next = S_RD_H;
                else if (w_timeout) w_next = S_ABORT;
            end
            S_RD_H:  w_next = S_RD_L;
            S_RD_L:  w_next = S_FIN;
            S_FIN:   w_next = S_OUT;
            S_ABORT: w_next = S_FIN;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        case (w_next)
            S_CLR1:  begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFS_OPCLEAR; w_din = 64'd1; end
            S_CLR0:  begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFS_OPCLEAR; w_din = 64'd0; end
            S_OPND:  begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFS_OPERAND; w_din = r_operand; end
            S_INTR:  begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFS_INTREN;  w_din = 64'd1; end
            S_START: begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFS_OPSTART; w_din = 64'd1; end
            S_RD_H:  begin w_sel = 1'b1; w_addr = BASE_ADDR + OFS_RESULT_H; end
            S_RD_L:  begin w_sel = 1'b1; w_addr = BASE_ADDR + OFS_RESULT_L; end
            S_FIN:   begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFS_OPSTART; w_din = 64'd0; end
            S_ABORT: begin w_sel = 1'b1; w_wr = 1'b1; w_addr = BASE_ADDR + OFS_OPCLEAR; w_din = 64'd1; end
            default: ;
        endcase
    end

    // Registered bus, operand latch, timeout counter, result capture and output valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_sel     <= 1'b0;
            r_s_wr      <= 1'b0;
            r_s_addr    <= '0;
            r_s_din     <= '0;
            r_operand   <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_s_sel  <= w_sel;
            r_s_wr   <= w_wr;
            r_s_addr <= w_addr;
            r_s_din  <= w_din;

            if (r_state == S_IDLE && in_valid)
                r_operand <= in_operand;

            if (r_state == S_WAIT)
                r_cnt <= w_cnt_inc;
            else if (w_next == S_WAIT)
                r_cnt <= '0;

            case (r_state)
                S_RD_H: begin
                    r_result[127:64] <= s_dout;
                    r_err            <= 1'b0;
                end
                S_RD_L:  r_result[63:0] <= s_dout;
                S_ABORT: begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                end
                default: ;
            endcase

            r_out_valid <= (w_next == S_OUT);
        end
    end

endmodule
